// File: rtl/quad_pkg.sv
// Shared constants, widths and step-decode helper for the quadrature decoder.
package quad_pkg;

    localparam int DEF_POS_W   = 16;
    localparam int DEF_SPD_W   = 12;
    localparam int DEF_WIN_CYC = 50000;
    localparam int ERR_W       = 8;

    // Phase-pair encodings {X,Y} in forward order.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        FWD     = 2'd1,
        REV     = 2'd2,
        ILLEGAL = 2'd3
    } dec_e;

    function automatic dec_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        dec_e res;
        case ({prev, cur})
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: res = FWD;
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: res = REV;
            {PH_00, PH_00}, {PH_10, PH_10}, {PH_11, PH_11}, {PH_01, PH_01}: res = NONE;
            default:                                                         res = ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Two-flop synchronizer for one asynchronous quadrature phase.
module quad_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next-state of the synchronizer chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronized phase decode, wrapping position, error
// counting and windowed speed measurement.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int POS_W   = DEF_POS_W,
    parameter int SPD_W   = DEF_SPD_W,
    parameter int WIN_CYC = DEF_WIN_CYC
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Pulse_X,
    input  logic               Pulse_Y,
    input  logic               Clr,
    output logic [POS_W-1:0]   Position,
    output logic               Dir,
    output logic               Step,
    output logic               Err,
    output logic [ERR_W-1:0]   Err_Cnt,
    output logic [SPD_W-1:0]   Speed,
    output logic               Speed_Vld
);

    localparam int               WIN_W    = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [SPD_W-1:0] SCNT_MAX = {SPD_W{1'b1}};

    logic             xs_s;
    logic             ys_s;
    logic [1:0]       cur_s;
    dec_e             dec_s;
    logic             step_now_s;
    logic [POS_W-1:0] pos_step_s;
    logic [ERR_W-1:0] ecnt_step_s;
    logic [SPD_W-1:0] scnt_inc_s;

    logic [1:0]       prev_d,  prev_q;
    logic [POS_W-1:0] pos_d,   pos_q;
    logic             dir_d,   dir_q;
    logic             step_d,  step_q;
    logic             err_d,   err_q;
    logic [ERR_W-1:0] ecnt_d,  ecnt_q;
    logic [WIN_W-1:0] win_d,   win_q;
    logic [SPD_W-1:0] scnt_d,  scnt_q;
    logic [SPD_W-1:0] speed_d, speed_q;
    logic             svld_d,  svld_q;

    quad_sync u_sync_x (.clk(sysclk), .rst_n(reset), .d(Pulse_X), .q(xs_s));
    quad_sync u_sync_y (.clk(sysclk), .rst_n(reset), .d(Pulse_Y), .q(ys_s));

    assign cur_s = {xs_s, ys_s};

    // Decode, position/error update and speed window next-state.
    always_comb begin
        dec_s       = quad_decode(prev_q, cur_s);
        prev_d      = cur_s;
        pos_step_s  = pos_q;
        ecnt_step_s = ecnt_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
        case (dec_s)
            FWD: begin
                pos_step_s = pos_q + POS_ONE;
                dir_d      = 1'b1;
                step_d     = 1'b1;
            end
            REV: begin
                pos_step_s = pos_q - POS_ONE;
                dir_d      = 1'b0;
                step_d     = 1'b1;
            end
            ILLEGAL: begin
                err_d       = 1'b1;
                ecnt_step_s = (ecnt_q == ERR_MAX) ? ecnt_q : (ecnt_q + 8'd1);
            end
            default: begin
                pos_step_s = pos_q;
            end
        endcase

        // Clear wins over a coincident step or error; pulses still go out.
        pos_d  = Clr ? {POS_W{1'b0}} : pos_step_s;
        ecnt_d = Clr ? {ERR_W{1'b0}} : ecnt_step_s;

        step_now_s = step_d;
        scnt_inc_s = (step_now_s && (scnt_q != SCNT_MAX)) ? (scnt_q + SPD_W'(1)) : scnt_q;
        speed_d    = speed_q;
        svld_d     = 1'b0;
        if (win_q == WIN_LAST) begin
            win_d   = {WIN_W{1'b0}};
            scnt_d  = {SPD_W{1'b0}};
            speed_d = scnt_inc_s;
            svld_d  = 1'b1;
        end else begin
            win_d   = win_q + WIN_W'(1);
            scnt_d  = scnt_inc_s;
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            prev_q  <= PH_00;
            pos_q   <= {POS_W{1'b0}};
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= {ERR_W{1'b0}};
            win_q   <= {WIN_W{1'b0}};
            scnt_q  <= {SPD_W{1'b0}};
            speed_q <= {SPD_W{1'b0}};
            svld_q  <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            win_q   <= win_d;
            scnt_q  <= scnt_d;
            speed_q <= speed_d;
            svld_q  <= svld_d;
        end
    end

    assign Position  = pos_q;
    assign Dir       = dir_q;
    assign Step      = step_q;
    assign Err       = err_q;
    assign Err_Cnt   = ecnt_q;
    assign Speed     = speed_q;
    assign Speed_Vld = svld_q;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter POS_W, default 16, width of signed position counter.
REQ-002 Parameter SPD_W, default 12, width of speed (steps-per-window) result.
REQ-003 Parameter WIN_CYC, default 50000, speed measurement window length in sysclk cycles (>=2).
REQ-004 sysclk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Pulse_X  input  1  quadrature phase X from pulse shaping stage; asynchronous to sysclk.
REQ-007 Pulse_Y  input  1  quadrature phase Y; asynchronous to sysclk.
REQ-008 Clr  input  1  synchronous clear of Position and Err_Cnt, active-high.
REQ-009 Position  output  POS_W  signed two's-complement step count.
REQ-010 Dir  output  1  direction of last valid step: 1 forward, 0 reverse.
REQ-011 Step  output  1  one-cycle pulse per valid step.
REQ-012 Err  output  1  one-cycle pulse per illegal transition.
REQ-013 Err_Cnt  output  8  saturating illegal-transition count.
REQ-014 Speed  output  SPD_W  valid steps counted in the last completed window.
REQ-015 Speed_Vld  output  1  one-cycle pulse when Speed updates.

Function
REQ-016 Each phase SHALL pass a 2-flop synchronizer; the decoder sees only synchronized values {Xs,Ys}.
REQ-017 A registered copy {Xp,Yp} of the previous synchronized pair SHALL be kept; decode compares {Xs,Ys} against {Xp,Yp} every cycle.
REQ-018 Forward sequence {X,Y}: 00->10->11->01->00; reverse is the opposite order.
REQ-019 Forward step: Position +1, Dir=1, Step=1; reverse step: Position -1, Dir=0, Step=1.
REQ-020 No change: Position, Dir held; Step=0, Err=0.
REQ-021 Both bits changed (00<->11, 10<->01): Position and Dir held, Err=1 one cycle, Err_Cnt +1 saturating at 255.
REQ-022 Position SHALL wrap modulo 2^POS_W (max positive +1 -> most negative; most negative -1 -> max positive), no flag.
REQ-023 Latency: an input edge stable across setup SHALL be reflected in Position/Step/Err on the 3rd rising sysclk edge after it.
REQ-024 Clr=1: Position=0 and Err_Cnt=0 at next edge, overriding any simultaneous step or error; Step/Err pulses still issue; Dir, Speed logic unaffected.
REQ-025 Window counter counts 0..WIN_CYC-1 then wraps; on the cycle it equals WIN_CYC-1 the step counter value (including a step in that same cycle) SHALL load into Speed and Speed_Vld=1 next cycle.
REQ-026 Step counter SHALL restart at 0 after each window load and saturate at 2^SPD_W-1 within a window.
REQ-027 First Speed_Vld SHALL occur exactly WIN_CYC cycles after reset release.

Reset
REQ-028 On reset low: synchronizers, {Xp,Yp}=00, Position=0, Dir=1, Step=0, Err=0, Err_Cnt=0, Speed=0, Speed_Vld=0, window and step counters=0.
REQ-029 Reset asserted mid-operation SHALL clear all state immediately; first decode after release treats prior inputs as 00, so a non-00 input at release produces one step or error per REQ-018/021.

Structure
REQ-030 Package quad_pkg SHALL hold the phase-pair encoding constants, the step-decode result enumeration (NONE, FWD, REV, ILLEGAL) and default widths.
REQ-031 Sub-module quad_sync (2-flop synchronizer, async active-low reset) SHALL be instantiated once per phase.
REQ-032 Decode, position, error and speed logic SHALL reside in quad_decoder.

Verification
REQ-033 Forward drive 00,10,11,01,00 x3 cycles, 20 sysclk apart -> Position=12, Dir=1, 12 Step pulses, Err_Cnt=0.
REQ-034 From Position=2, reverse 5 steps -> Position=-3 (0xFFFD), Dir=0.
REQ-035 Jump 00->11 twice, then 300 illegal jumps -> Err pulses each, Position unchanged, Err_Cnt=255.
REQ-036 WIN_CYC=100, 7 forward steps in window, one on cycle 99 -> Speed=7, Speed_Vld at cycle 100; empty next window -> Speed=0.
REQ-037 Position=0x7FFF, one forward step with Clr asserted same cycle -> Position=0; repeat without Clr from 0x7FFF -> 0x8000.
REQ-038 Reset asserted mid-sequence with inputs at 11 -> all outputs reset values; after release one Err pulse, Err_Cnt=1.
